// File: rtl/router_pkg.sv
// Shared router-side definitions: packet widths, link type codes and the node TX queue FSM states.
package router_pkg;

    localparam int PKT_NODE_W    = 29;
    localparam int PKT_LINK_W    = 55;
    localparam int PKT_TO_NODE_W = 24;

    typedef enum logic [2:0] {
        LINK_ACK   = 3'b000,
        LINK_NACK  = 3'b011,
        LINK_TOKEN = 3'b111
    } link_type_t;

    typedef enum logic [1:0] {
        NQ_IDLE    = 2'd0,
        NQ_OFFER   = 2'd1,
        NQ_RELEASE = 2'd2
    } nq_state_t;

endpackage

// File: rtl/node_tx_queue_if.sv
// Node-logic enqueue handshake and router-core load handshake of the node TX queue.
interface node_tx_queue_if #(
    parameter int PKT_W = 29
);
    logic             enq_valid;
    logic             enq_ready;
    logic [PKT_W-1:0] enq_packet;
    logic [PKT_W-1:0] Packet_From_Node;
    logic             Packet_From_Node_Valid;
    logic             Core_Load_Ack;

    modport master (
        input  enq_valid, enq_packet, Core_Load_Ack,
        output enq_ready, Packet_From_Node, Packet_From_Node_Valid
    );

    modport slave (
        output enq_valid, enq_packet, Core_Load_Ack,
        input  enq_ready, Packet_From_Node, Packet_From_Node_Valid
    );
endinterface

// File: rtl/node_q_ram.sv
// DEPTH x PKT_W packet store: one synchronous write port, one asynchronous read port, no reset.
module node_q_ram #(
    parameter int DEPTH = 4,
    parameter int PKT_W = 29
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [PKT_W-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [PKT_W-1:0]         rdata
);
    logic [PKT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/node_tx_queue.sv
// Node-side outbound packet queue feeding the router core load port (offer / ack / release).
// Optional NODE_Q_TIMEOUT_EN adds a sticky stall_err after TIMEOUT unacknowledged OFFER cycles.
module node_tx_queue
    import router_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PKT_W   = PKT_NODE_W,
    parameter int TIMEOUT = 255
) (
    input  logic                       Clk_R,
    input  logic                       Rst_n,
    node_tx_queue_if.master            bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       stall_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_param
        $error("node_tx_queue: DEPTH must be a power of two in 2..16, TIMEOUT in 1..255");
    end

    nq_state_t        state;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count_next;
    logic [PKT_W-1:0] head;
    logic             enq_fire;
    logic             pop;

    assign enq_fire = bus.enq_valid && bus.enq_ready;
    // Only an acknowledged OFFER pops; OFFER is entered only with count != 0.
    assign pop      = (state == NQ_OFFER) && bus.Core_Load_Ack;

    always_comb begin
        count_next = count;
        case ({enq_fire, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    node_q_ram #(.DEPTH(DEPTH), .PKT_W(PKT_W)) u_ram (
        .clk   (Clk_R),
        .we    (enq_fire),
        .waddr (wr_ptr),
        .wdata (bus.enq_packet),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            state                      <= NQ_IDLE;
            bus.Packet_From_Node_Valid <= 1'b0;
            rd_ptr                     <= '0;
            wr_ptr                     <= '0;
            count                      <= '0;
            full                       <= 1'b0;
            empty                      <= 1'b1;
            bus.enq_ready              <= 1'b1;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + AW'(1);
            if (pop)      rd_ptr <= rd_ptr + AW'(1);
            count         <= count_next;
            full          <= (count_next == DEPTH_C);
            empty         <= (count_next == '0);
            bus.enq_ready <= (count_next != DEPTH_C);

            case (state)
                NQ_IDLE: begin
                    if (count != '0) begin
                        state                      <= NQ_OFFER;
                        bus.Packet_From_Node_Valid <= 1'b1;
                    end
                end
                NQ_OFFER: begin
                    if (bus.Core_Load_Ack) begin
                        state                      <= NQ_RELEASE;
                        bus.Packet_From_Node_Valid <= 1'b0;
                    end
                end
                NQ_RELEASE: begin
                    // A level ack held across cycles must fall before the next offer.
                    if (!bus.Core_Load_Ack) state <= NQ_IDLE;
                end
                default: begin
                    state                      <= NQ_IDLE;
                    bus.Packet_From_Node_Valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Packet_From_Node = bus.Packet_From_Node_Valid ? head : '0;

`ifdef NODE_Q_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    logic [7:0] wait_cnt;

    // Counter restarts in IDLE so each OFFER episode is timed from its entry.
    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            wait_cnt  <= '0;
            stall_err <= 1'b0;
        end else if (state == NQ_IDLE) begin
            wait_cnt <= '0;
        end else if ((state == NQ_OFFER) && !bus.Core_Load_Ack) begin
            if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
            if ((wait_cnt + 8'd1) == TIMEOUT_C) stall_err <= 1'b1;
        end
    end
`else
    assign stall_err = 1'b0;
`endif

endmodule
